mem_onchip_pipe: RTL and testbench
==================================

# mem_onchip_pipe

Parametrised Avalon-MM on-chip RAM slave, successor to the fixed 1K×32 single-cycle memory instances in the system design. It adds configurable width, depth and read latency, plus pipelined reads with `readdatavalid`, fixed-increment read bursts with address wrap, and a hardware clear sequence after reset. It sits on the system interconnect as a general-purpose scratch/data memory.

## Interface
- `DATA_W`, 32, data width; multiple of 8, range 8..128
- `ADDR_W`, 10, word address width; depth `DEPTH = 2**ADDR_W`
- `READ_LATENCY`, 2, cycles from read accept to first `readdatavalid`; range 1..4
- `BURST_W`, 4, `burstcount` width; max burst `2**(BURST_W-1)`
- `CLEAR_ON_RESET`, 1, 1 = zero all words after reset, 0 = skip clear

- `clk` in 1, single clock
- `reset_n` in 1, asynchronous, active-low reset
- `address` in ADDR_W, word address
- `chipselect` in 1, slave select
- `clken` in 1, clock enable; 0 freezes the whole block
- `read` in 1, read request
- `write` in 1, write request
- `writedata` in DATA_W, write data
- `byteenable` in DATA_W/8, write lane enables
- `burstcount` in BURST_W, read burst length; 0 is treated as 1
- `readdata` out DATA_W, read data
- `readdatavalid` out 1, `readdata` qualifier
- `waitrequest` out 1, command not accepted this cycle

## Operation
- **Reset values:** `readdata=0`, `readdatavalid=0`, `waitrequest=1`. The read pipeline is flushed, the FSM goes to CLEAR, or to IDLE if `CLEAR_ON_RESET=0`.
- **Command accept:** a command is accepted when `chipselect & clken & (read|write) & !waitrequest`.
- **FSM states:** CLEAR, IDLE, RBURST.
- **CLEAR:**
  - `clr_ptr` runs 0..DEPTH-1, writing all-zero words with all lanes enabled, one per cycle.
  - `waitrequest=1` throughout.
  - After writing `DEPTH-1`, the FSM goes to IDLE.
- **IDLE:**
  - `waitrequest=0` unless `clken=0`.
  - Write: a single beat; `burstcount` is ignored. Only lanes with `byteenable[i]=1` are updated, bits `[8i+7:8i]`.
  - Read with effective burst N=1: the address is issued to the RAM and the FSM stays in IDLE.
  - Read with N>1: address A is issued, the remaining count `N-1` and next address `A+1` are latched, and the FSM goes to RBURST.
  - `read` and `write` both high: the write executes and the read is dropped; no `readdatavalid` is generated.
- **RBURST:**
  - `waitrequest=1`.
  - Issues one address per cycle, incrementing modulo DEPTH, so `DEPTH-1` wraps to 0.
  - After the last beat is issued, the FSM returns to IDLE; `waitrequest` drops on the following cycle.
- **Read pipeline:** a shift register of depth `READ_LATENCY` carries the valid bit alongside the RAM output register chain.
- **Read ordering:** data returns in issue order, with no gaps within a burst.
- **Read-after-write:** a read accepted the cycle after a write to the same address returns the new data. There is no same-cycle read/write conflict, because only one command is issued per cycle.
- **`clken=0`:**
  - FSM, `clr_ptr`, burst counter, RAM access and read pipeline all hold.
  - `readdata` and `readdatavalid` hold their values.
  - `waitrequest` is forced to 1.
- **Reset mid-operation:** the outstanding burst is abandoned and the pipeline is cleared immediately (asynchronous). With `CLEAR_ON_RESET=1`, memory contents are zero after CLEAR completes. With `CLEAR_ON_RESET=0`, contents are retained and unspecified.

## Timing
- **Reset release:** `waitrequest` stays 1 for exactly DEPTH cycles with `clken=1` (cycles 0..DEPTH-1 after the first `clk` edge with `reset_n=1`). It is 0 from cycle DEPTH.
- **Read latency:** a read accepted at edge t gives `readdatavalid=1` with data at edge `t+READ_LATENCY`.
- **Burst of N accepted at t:**
  - `waitrequest=1` for cycles t+1..t+N-1.
  - `readdatavalid=1` on N consecutive cycles, t+L..t+L+N-1.
  - The next command can be accepted at t+N.
- **Single-beat throughput:** back-to-back single reads or writes complete one per cycle. A read may immediately follow a burst's last issue.
- **Write latency:** a write takes effect at the accepting edge. There is no response.
- **Stall accounting:** all latencies are counted in cycles with `clken=1`.

## Test plan
- **Post-reset clear:** preload garbage via backdoor, pulse `reset_n` low, release, keep `clken=1` -> `waitrequest` high for 1024 cycles (default params), then a read of 0x3FF returns 0x00000000 two cycles later.
- **Byte-lane write:** write 0xAABBCCDD to 0x010 with `byteenable=1111`, then 0x11223344 with `byteenable=0101` -> a read of 0x010 returns 0xAA22CC44.
- **Wrapping burst:** write word value k to addresses 0x3FE, 0x3FF, 0x000, 0x001; read A=0x3FE, `burstcount=4` -> 4 contiguous valid beats in that order, and `waitrequest` high exactly 3 cycles.
- **Stall mid-burst:** as the previous scenario, with `clken=0` for 5 cycles after beat 1 is issued -> outputs hold, no extra or lost beats, total beats = 4 and the values are unchanged.
- **Reset during burst:** `burstcount=8` read, assert `reset_n=0` after beat 3 is returned -> `readdatavalid` goes to 0 immediately and no further beats appear after release; CLEAR restarts.
- **Latency sweep:** repeat the single-read check with `READ_LATENCY`=1,3,4 and `DATA_W`=64 -> first valid exactly L cycles after accept; also issue a simultaneous read+write -> the write lands and no `readdatavalid` is generated.

Source files
------------

// File: rtl/mem_onchip_pipe.sv
// mem_onchip_pipe: parameterised Avalon-MM on-chip RAM slave.
// Byte-lane RAM banks, pipelined reads with readdatavalid, fixed-increment
// read bursts that wrap at the top of memory, and a zero-fill sequence after
// reset. clken=0 freezes every piece of state in the block.

// One byte lane of storage. Combinational read; the top-level read pipeline
// provides the output registers, so the first pipe stage captures the RAM
// word on the issuing edge.
module mem_onchip_lane #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH];

    // Lane write port; write lands at the accepting edge.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

module mem_onchip_pipe #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 10,
    parameter int READ_LATENCY   = 2,
    parameter int BURST_W        = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic                chipselect,
    input  logic                clken,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [BURST_W-1:0]  burstcount,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest
);
    localparam int NUM_LANES = DATA_W / 8;
    localparam int DEPTH     = 2 ** ADDR_W;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RBURST} state_t;

    // One RAM operation per cycle, whoever originates it (clear, bus, burst).
    typedef struct packed {
        logic                       rd;
        logic                       wr;
        logic [ADDR_W-1:0]          addr;
        logic [NUM_LANES-1:0]       be;
        logic [NUM_LANES-1:0][7:0]  wdata;
    } ram_req_t;

    state_t                      state;
    logic [ADDR_W-1:0]           clr_ptr;
    logic [ADDR_W-1:0]           burst_addr;
    logic [BURST_W-1:0]          burst_left;
    logic [BURST_W-1:0]          bc_eff;
    logic                        accept;
    logic                        rd_issue;
    ram_req_t                    req;
    logic [NUM_LANES-1:0][7:0]   ram_rdata;
    logic [READ_LATENCY:1]       vld_pipe;
    logic [READ_LATENCY:1][DATA_W-1:0] data_pipe;

    // Bus sees the slave busy whenever it is not idle or is frozen.
    assign waitrequest = !reset_n || !clken || (state != S_IDLE);
    assign accept      = chipselect && clken && (read || write) && !waitrequest;
    assign bc_eff      = (burstcount == '0) ? BURST_W'(1) : burstcount;

    // Select the single RAM operation for this cycle.
    always_comb begin
        req = '0;
        case (state)
            S_CLEAR: begin
                req.wr   = 1'b1;
                req.addr = clr_ptr;
                req.be   = '1;
            end
            S_IDLE: begin
                if (accept) begin
                    req.addr = address;
                    if (write) begin
                        // write wins over a simultaneous read; read is dropped
                        req.wr    = 1'b1;
                        req.be    = byteenable;
                        req.wdata = writedata;
                    end else begin
                        req.rd = 1'b1;
                    end
                end
            end
            S_RBURST: begin
                req.rd   = 1'b1;
                req.addr = burst_addr;
            end
            default: ;
        endcase
    end

    assign rd_issue = req.rd && clken;

    // Byte-lane banks; each lane writes only when its enable is set.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mem_onchip_lane #(.ADDR_W(ADDR_W)) u_lane (
            .clk   (clk),
            .we    (reset_n && clken && req.wr && req.be[i]),
            .addr  (req.addr),
            .wdata (req.wdata[i]),
            .rdata (ram_rdata[i])
        );
    end

    // Control FSM: clear sweep, idle command accept, burst address issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if (CLEAR_ON_RESET != 0) state <= S_CLEAR;
            else                     state <= S_IDLE;
            clr_ptr    <= '0;
            burst_addr <= '0;
            burst_left <= '0;
        end else if (clken) begin
            case (state)
                S_CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == ADDR_W'(DEPTH - 1)) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (accept && read && !write && bc_eff != BURST_W'(1)) begin
                        burst_left <= bc_eff - BURST_W'(1);
                        burst_addr <= address + ADDR_W'(1);
                        state      <= S_RBURST;
                    end
                end
                S_RBURST: begin
                    // address wraps naturally at the top of memory
                    burst_addr <= burst_addr + ADDR_W'(1);
                    burst_left <= burst_left - BURST_W'(1);
                    if (burst_left == BURST_W'(1)) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read pipeline: valid bit travels alongside the data, frozen by clken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else if (clken) begin
            vld_pipe[1]  <= rd_issue;
            data_pipe[1] <= ram_rdata;
            for (int s = 2; s <= READ_LATENCY; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                data_pipe[s] <= data_pipe[s-1];
            end
        end
    end

    assign readdatavalid = vld_pipe[READ_LATENCY];
    assign readdata      = data_pipe[READ_LATENCY];
endmodule

// File: tb/tb_mem_onchip_pipe.sv
// Directed bench for mem_onchip_pipe: default-parameter instance for clear,
// byte lanes, bursts, stalls and reset; three small 64-bit instances for the
// read-latency sweep and the read+write collision case.
module tb_mem_onchip_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [9:0]  address;
    logic        chipselect, clken, read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [3:0]  burstcount;
    logic [31:0] readdata;
    logic        readdatavalid, waitrequest;

    logic [3:0]  s_address;
    logic        s_cs, s_clken, s_read, s_write;
    logic [63:0] s_wdata;
    logic [7:0]  s_be;
    logic [3:0]  s_bc;
    logic [63:0] rd1, rd3, rd4;
    logic        v1, v3, v4, w1, w3, w4;

    int tests = 0;
    int fails = 0;

    mem_onchip_pipe dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .clken(clken), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .burstcount(burstcount), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest)
    );

    mem_onchip_pipe #(.DATA_W(64), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .reset_n(reset_n), .address(s_address), .chipselect(s_cs),
        .clken(s_clken), .read(s_read), .write(s_write), .writedata(s_wdata),
        .byteenable(s_be), .burstcount(s_bc), .readdata(rd1),
        .readdatavalid(v1), .waitrequest(w1)
    );

    mem_onchip_pipe #(.DATA_W(64), .ADDR_W(4), .READ_LATENCY(3), .CLEAR_ON_RESET(1)) u3 (
        .clk(clk), .reset_n(reset_n), .address(s_address), .chipselect(s_cs),
        .clken(s_clken), .read(s_read), .write(s_write), .writedata(s_wdata),
        .byteenable(s_be), .burstcount(s_bc), .readdata(rd3),
        .readdatavalid(v3), .waitrequest(w3)
    );

    mem_onchip_pipe #(.DATA_W(64), .ADDR_W(4), .READ_LATENCY(4), .CLEAR_ON_RESET(0)) u4 (
        .clk(clk), .reset_n(reset_n), .address(s_address), .chipselect(s_cs),
        .clken(s_clken), .read(s_read), .write(s_write), .writedata(s_wdata),
        .byteenable(s_be), .burstcount(s_bc), .readdata(rd4),
        .readdatavalid(v4), .waitrequest(w4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge where reset_n was released; counts busy cycles.
    task automatic wait_clear(output int cnt, output int vs);
        cnt = 0;
        vs  = 0;
        while (waitrequest === 1'b1 && cnt < 5000) begin
            @(negedge clk);
            cnt++;
            if (readdatavalid) vs++;
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        address = a; writedata = d; byteenable = be; burstcount = 4'd3;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd_single(input logic [9:0] a, input logic [31:0] e, input string tg);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a; burstcount = 4'd0;
        #1 check({tg, "_acc"}, 64'(waitrequest), 64'd0);
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        check({tg, "_early"}, 64'(readdatavalid), 64'd0);
        @(negedge clk);
        check({tg, "_vld"}, 64'(readdatavalid), 64'd1);
        check({tg, "_data"}, 64'(readdata), 64'(e));
    endtask

    task automatic small_read(input logic [3:0] a, input logic [63:0] e, input string tg);
        int f1, f3, f4;
        logic [63:0] d1, d3, d4;
        f1 = -1; f3 = -1; f4 = -1; d1 = '0; d3 = '0; d4 = '0;
        s_cs = 1'b1; s_read = 1'b1; s_write = 1'b0; s_address = a; s_bc = 4'd1;
        @(negedge clk);
        s_cs = 1'b0; s_read = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (v1 && f1 < 0) begin f1 = c; d1 = rd1; end
            if (v3 && f3 < 0) begin f3 = c; d3 = rd3; end
            if (v4 && f4 < 0) begin f4 = c; d4 = rd4; end
            @(negedge clk);
        end
        check({tg, "_lat1"}, 64'(f1), 64'd1);
        check({tg, "_lat3"}, 64'(f3), 64'd3);
        check({tg, "_lat4"}, 64'(f4), 64'd4);
        check({tg, "_d1"}, d1, e);
        check({tg, "_d3"}, d3, e);
        check({tg, "_d4"}, d4, e);
    endtask

    initial begin
        int cnt, vs, wcnt, nb, first, last, c;
        logic [31:0] beats [8];

        reset_n = 1'b0; clken = 1'b1;
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0; byteenable = '0; burstcount = '0;
        s_cs = 1'b0; s_clken = 1'b1; s_read = 1'b0; s_write = 1'b0;
        s_address = '0; s_wdata = '0; s_be = '0; s_bc = '0;
        foreach (beats[i]) beats[i] = '0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_rdata", 64'(readdata), 64'd0);
        check("rst_rvalid", 64'(readdatavalid), 64'd0);
        check("rst_wait", 64'(waitrequest), 64'd1);
        check("rst_wait_noclr", 64'(w4), 64'd1);
        reset_n = 1'b1;
        #1 check("noclr_wait", 64'(w4), 64'd0);
        wait_clear(cnt, vs);
        check("clr_cycles", 64'(cnt), 64'd1024);

        // garbage, then reset: clear must zero it
        wr(10'h3FF, 32'hDEADBEEF, 4'hF);
        wr(10'h010, 32'h12345678, 4'hF);
        rd_single(10'h3FF, 32'hDEADBEEF, "raw");
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        wait_clear(cnt, vs);
        check("clr2_cycles", 64'(cnt), 64'd1024);
        rd_single(10'h3FF, 32'h0, "clr_3ff");
        rd_single(10'h010, 32'h0, "clr_010");

        // byte lanes
        wr(10'h010, 32'hAABBCCDD, 4'hF);
        wr(10'h010, 32'h11223344, 4'h5);
        rd_single(10'h010, 32'hAA22CC44, "lanes");

        // wrapping burst
        wr(10'h3FE, 32'h100, 4'hF);
        wr(10'h3FF, 32'h101, 4'hF);
        wr(10'h000, 32'h102, 4'hF);
        wr(10'h001, 32'h103, 4'hF);
        chipselect = 1'b1; read = 1'b1; address = 10'h3FE; burstcount = 4'd4;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        wcnt = 0; nb = 0; first = -1; last = -1;
        for (int k = 1; k <= 10; k++) begin
            if (waitrequest) wcnt++;
            if (readdatavalid) begin
                if (nb < 8) beats[nb] = readdata;
                nb++;
                if (first < 0) first = k;
                last = k;
            end
            @(negedge clk);
        end
        check("wb_wait", 64'(wcnt), 64'd3);
        check("wb_beats", 64'(nb), 64'd4);
        check("wb_first", 64'(first), 64'd2);
        check("wb_last", 64'(last), 64'd5);
        for (int k = 0; k < 4; k++) check("wb_data", 64'(beats[k]), 64'(32'h100 + k));

        // same burst with a 5-cycle stall after beat 1 is issued
        chipselect = 1'b1; read = 1'b1; address = 10'h3FE; burstcount = 4'd4;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        nb = 0; first = -1; last = -1;
        foreach (beats[i]) beats[i] = '0;
        for (int k = 1; k <= 16; k++) begin
            clken = !(k >= 2 && k <= 6);
            #1;
            if (k == 4) begin
                check("st_hold_v", 64'(readdatavalid), 64'd1);
                check("st_hold_d", 64'(readdata), 64'h100);
                check("st_wait", 64'(waitrequest), 64'd1);
            end
            if (readdatavalid && clken) begin
                if (nb < 8) beats[nb] = readdata;
                nb++;
                if (first < 0) first = k;
                last = k;
            end
            @(negedge clk);
        end
        clken = 1'b1;
        check("st_beats", 64'(nb), 64'd4);
        check("st_first", 64'(first), 64'd7);
        check("st_last", 64'(last), 64'd10);
        for (int k = 0; k < 4; k++) check("st_data", 64'(beats[k]), 64'(32'h100 + k));

        // reset in the middle of an 8-beat burst
        chipselect = 1'b1; read = 1'b1; address = 10'h020; burstcount = 4'd8;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        c = 1; nb = 0;
        while (c < 20) begin
            if (readdatavalid) nb++;
            if (nb == 3) break;
            @(negedge clk);
            c++;
        end
        check("rb_three", 64'(nb), 64'd3);
        reset_n = 1'b0;
        #1;
        check("rb_vld0", 64'(readdatavalid), 64'd0);
        check("rb_wait1", 64'(waitrequest), 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_clear(cnt, vs);
        check("rb_clr_cycles", 64'(cnt), 64'd1024);
        check("rb_stray_beats", 64'(vs), 64'd0);
        rd_single(10'h3FF, 32'h0, "rb_3ff");

        // latency sweep on 64-bit instances
        s_cs = 1'b1; s_write = 1'b1; s_address = 4'd5;
        s_wdata = 64'h0123456789ABCDEF; s_be = 8'hFF;
        #1 check("sw_wait", 64'({w1, w3, w4}), 64'd0);
        @(negedge clk);
        s_cs = 1'b0; s_write = 1'b0;
        small_read(4'd5, 64'h0123456789ABCDEF, "lat");
        s_cs = 1'b1; s_write = 1'b1; s_address = 4'd5;
        s_wdata = 64'hFFFFFFFF00000000; s_be = 8'hF0;
        @(negedge clk);
        s_cs = 1'b0; s_write = 1'b0;
        small_read(4'd5, 64'hFFFFFFFF89ABCDEF, "lat_be");

        // read and write together: write lands, no read response
        s_cs = 1'b1; s_read = 1'b1; s_write = 1'b1; s_address = 4'd7;
        s_wdata = 64'hFEEDFACECAFEF00D; s_be = 8'hFF; s_bc = 4'd1;
        @(negedge clk);
        s_cs = 1'b0; s_read = 1'b0; s_write = 1'b0;
        vs = 0;
        for (int k = 1; k <= 8; k++) begin
            if (v1 || v3 || v4) vs++;
            @(negedge clk);
        end
        check("rw_no_valid", 64'(vs), 64'd0);
        small_read(4'd7, 64'hFEEDFACECAFEF00D, "rw");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
